// File: rtl/tia_collision_detector_pkg.sv
// Shared constants for the TIA collision detector: object indices,
// collision latch bit positions, the pair wiring table and read addresses.
package tia_collision_detector_pkg;

    localparam int unsigned NUM_CX  = 15;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned NUM_OBJ = 6;
    localparam int unsigned OBJ_W   = 3;

    // Position of each graphics object in the packed object vector
    localparam logic [OBJ_W-1:0] OBJ_P0 = OBJ_W'(0);
    localparam logic [OBJ_W-1:0] OBJ_M0 = OBJ_W'(1);
    localparam logic [OBJ_W-1:0] OBJ_P1 = OBJ_W'(2);
    localparam logic [OBJ_W-1:0] OBJ_M1 = OBJ_W'(3);
    localparam logic [OBJ_W-1:0] OBJ_BL = OBJ_W'(4);
    localparam logic [OBJ_W-1:0] OBJ_PF = OBJ_W'(5);

    // Collision latch bit indices
    localparam int unsigned CX_M0P1 = 0;
    localparam int unsigned CX_M0P0 = 1;
    localparam int unsigned CX_M1P0 = 2;
    localparam int unsigned CX_M1P1 = 3;
    localparam int unsigned CX_P0PF = 4;
    localparam int unsigned CX_P0BL = 5;
    localparam int unsigned CX_P1PF = 6;
    localparam int unsigned CX_P1BL = 7;
    localparam int unsigned CX_M0PF = 8;
    localparam int unsigned CX_M0BL = 9;
    localparam int unsigned CX_M1PF = 10;
    localparam int unsigned CX_M1BL = 11;
    localparam int unsigned CX_BLPF = 12;
    localparam int unsigned CX_P0P1 = 13;
    localparam int unsigned CX_M0M1 = 14;

    // First and second object of each latch, indexed by latch bit
    localparam logic [OBJ_W-1:0] CX_OBJ_A [NUM_CX] = '{
        OBJ_M0, OBJ_M0, OBJ_M1, OBJ_M1, OBJ_P0, OBJ_P0, OBJ_P1, OBJ_P1,
        OBJ_M0, OBJ_M0, OBJ_M1, OBJ_M1, OBJ_BL, OBJ_P0, OBJ_M0
    };
    localparam logic [OBJ_W-1:0] CX_OBJ_B [NUM_CX] = '{
        OBJ_P1, OBJ_P0, OBJ_P0, OBJ_P1, OBJ_PF, OBJ_BL, OBJ_PF, OBJ_BL,
        OBJ_PF, OBJ_BL, OBJ_PF, OBJ_BL, OBJ_PF, OBJ_P1, OBJ_M1
    };

    // CPU read addresses of the collision registers
    localparam logic [ADDR_W-1:0] CX_ADDR_M0P  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] CX_ADDR_M1P  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CX_ADDR_P0FB = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] CX_ADDR_P1FB = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] CX_ADDR_M0FB = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] CX_ADDR_M1FB = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] CX_ADDR_BLPF = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] CX_ADDR_PPMM = ADDR_W'(7);

endpackage

// File: rtl/tia_collision_latch.sv
// One sticky collision bit: sets on a & b while enabled, clears on clr or reset.
module tia_collision_latch (
    input  logic clkp,
    input  logic reset_bar,
    input  logic a,
    input  logic b,
    input  logic enable,
    input  logic clr,
    output logic q
);

    logic r_q;

    // Clear has priority; otherwise accumulate coincidence while enabled
    always_ff @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) begin
            r_q <= 1'b0;
        end else if (clr) begin
            r_q <= 1'b0;
        end else if (enable) begin
            r_q <= r_q | (a & b);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tia_collision_detector.sv
// TIA collision detector: 15 sticky pairwise latches over the six graphics
// objects, read back two bits at a time through a combinational mux.
module tia_collision_detector
    import tia_collision_detector_pkg::*;
(
    input  logic              clkp,
    input  logic              reset_bar,
    input  logic              p0,
    input  logic              m0,
    input  logic              p1,
    input  logic              m1,
    input  logic              bl,
    input  logic              pf,
    input  logic              blank,
    input  logic              cxclr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              d7,
    output logic              d6
);

    logic [NUM_OBJ-1:0] w_obj;
    logic [NUM_CX-1:0]  w_cx;
    logic               w_enable;

    assign w_obj    = {pf, bl, m1, p1, m0, p0};
    assign w_enable = ~blank;

    // One latch per unordered object pair, wired from the pair table
    for (genvar g = 0; g < NUM_CX; g++) begin : g_cx
        tia_collision_latch u_latch (
            .clkp      (clkp),
            .reset_bar (reset_bar),
            .a         (w_obj[CX_OBJ_A[g]]),
            .b         (w_obj[CX_OBJ_B[g]]),
            .enable    (w_enable),
            .clr       (cxclr),
            .q         (w_cx[g])
        );
    end

    // Read mux off latch outputs, forced to zero when not reading
    always_comb begin
        d7 = 1'b0;
        d6 = 1'b0;
        if (rd_en) begin
            case (rd_addr)
                CX_ADDR_M0P:  begin d7 = w_cx[CX_M0P1]; d6 = w_cx[CX_M0P0]; end
                CX_ADDR_M1P:  begin d7 = w_cx[CX_M1P0]; d6 = w_cx[CX_M1P1]; end
                CX_ADDR_P0FB: begin d7 = w_cx[CX_P0PF]; d6 = w_cx[CX_P0BL]; end
                CX_ADDR_P1FB: begin d7 = w_cx[CX_P1PF]; d6 = w_cx[CX_P1BL]; end
                CX_ADDR_M0FB: begin d7 = w_cx[CX_M0PF]; d6 = w_cx[CX_M0BL]; end
                CX_ADDR_M1FB: begin d7 = w_cx[CX_M1PF]; d6 = w_cx[CX_M1BL]; end
                CX_ADDR_BLPF: begin d7 = w_cx[CX_BLPF]; d6 = 1'b0;          end
                CX_ADDR_PPMM: begin d7 = w_cx[CX_P0P1]; d6 = w_cx[CX_M0M1]; end
                default:      begin d7 = 1'b0;          d6 = 1'b0;          end
            endcase
        end
    end

endmodule

// File: tb/tb_tia_collision_detector.sv
// Scoreboard bench for tia_collision_detector: directed stimulus pushes
// expected {d7,d6} per read, a monitor pops and compares when a read is presented.
module tb_tia_collision_detector;

    typedef struct {
        logic [1:0] exp;
        string      name;
    } sb_entry_t;

    logic       clkp;
    logic       reset_bar;
    logic       p0, m0, p1, m1, bl, pf;
    logic       blank;
    logic       cxclr;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       d7, d6;

    sb_entry_t  sb_q[$];
    int         checks;
    int         errors;
    int         n_push;
    int         n_pop;
    logic       force_chk;
    event       ev_sample;

    tia_collision_detector dut (
        .clkp      (clkp),
        .reset_bar (reset_bar),
        .p0        (p0),
        .m0        (m0),
        .p1        (p1),
        .m1        (m1),
        .bl        (bl),
        .pf        (pf),
        .blank     (blank),
        .cxclr     (cxclr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .d7        (d7),
        .d6        (d6)
    );

    initial clkp = 1'b0;
    always #5 clkp = ~clkp;

    // Monitor: compare a presented read (negedge with rd_en, or forced sample)
    always @(negedge clkp or ev_sample) begin
        if (rd_en || force_chk) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got %b with empty scoreboard", {d7, d6});
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                n_pop++;
                checks++;
                if ({d7, d6} !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, {d7, d6}, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clkp);
        #1;
    endtask

    task automatic push(input logic [1:0] exp, input string name);
        sb_entry_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        n_push++;
    endtask

    // Objects vector order: {pf, bl, m1, p1, m0, p0}
    task automatic set_obj(input logic [5:0] v);
        {pf, bl, m1, p1, m0, p0} = v;
    endtask

    // Present one read for a cycle; the monitor checks it at the negedge
    task automatic rd(input logic [2:0] a, input logic [1:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        push(exp, name);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic pulse_obj(input logic [5:0] v);
        set_obj(v);
        tick();
        set_obj(6'b0);
    endtask

    task automatic do_clear();
        cxclr = 1'b1;
        tick();
        cxclr = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n_push    = 0;
        n_pop     = 0;
        force_chk = 1'b0;
        reset_bar = 1'b0;
        blank     = 1'b0;
        cxclr     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = 3'd0;
        set_obj(6'b000101);   // p0 = p1 = 1 during reset

        // 1. Reset holds latches at zero even with overlapping inputs
        repeat (3) tick();
        rd(3'd7, 2'b00, "reset_hold_addr7");
        reset_bar = 1'b1;
        set_obj(6'b0);
        rd(3'd7, 2'b00, "reset_release_addr7");
        rd(3'd0, 2'b00, "reset_release_addr0");

        // 2. Single overlap p0 & m0 -> M0P0, sticky over 100 cycles
        pulse_obj(6'b000011);
        rd(3'd0, 2'b01, "m0p0_set");
        rd(3'd7, 2'b00, "m0p0_no_p0p1");
        repeat (100) tick();
        rd(3'd0, 2'b01, "m0p0_sticky");
        // read gating: rd_en low forces zero outputs
        rd_addr   = 3'd0;
        push(2'b00, "rd_en_gating");
        force_chk = 1'b1;
        -> ev_sample;
        #1 force_chk = 1'b0;
        tick();

        // 3. Blank suppresses detection
        do_clear();
        blank = 1'b1;
        set_obj(6'b111111);
        repeat (10) tick();
        set_obj(6'b0);
        blank = 1'b0;
        for (int a = 0; a < 8; a++) rd(3'(a), 2'b00, $sformatf("blank_addr%0d", a));

        // 4. Clear wins over same-edge overlap; detection resumes next edge
        set_obj(6'b010100);   // p1, bl
        cxclr = 1'b1;
        tick();
        cxclr = 1'b0;
        rd(3'd3, 2'b00, "clr_priority");   // p1 & bl still high; sampled pre-edge
        set_obj(6'b0);
        rd(3'd3, 2'b01, "clr_resume_p1bl");

        // 5. Triple overlap p0 & p1 & pf
        do_clear();
        pulse_obj(6'b100101);
        rd(3'd2, 2'b10, "triple_addr2");
        rd(3'd3, 2'b10, "triple_addr3");
        rd(3'd7, 2'b10, "triple_addr7");
        rd(3'd6, 2'b00, "triple_addr6");

        // Read during update returns the pre-edge value
        set_obj(6'b100010);   // m0, pf
        rd(3'd4, 2'b00, "rd_same_cycle_pre");
        set_obj(6'b0);
        rd(3'd4, 2'b10, "rd_same_cycle_post");

        // 6. All latches set, then async reset between edges
        do_clear();
        pulse_obj(6'b111111);
        for (int a = 0; a < 6; a++) rd(3'(a), 2'b11, $sformatf("all_addr%0d", a));
        rd(3'd6, 2'b10, "all_addr6");
        rd_en   = 1'b1;
        rd_addr = 3'd7;
        push(2'b11, "all_addr7");
        @(negedge clkp);
        #1 reset_bar = 1'b0;
        push(2'b00, "async_reset_no_edge");
        #1 force_chk = 1'b1;
        -> ev_sample;
        #1 force_chk = 1'b0;
        reset_bar = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int a = 0; a < 8; a++) rd(3'(a), 2'b00, $sformatf("post_reset_addr%0d", a));

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        checks++;
        if (n_pop != n_push) begin
            errors++;
            $display("FAIL scoreboard_drain: popped %0d expected %0d", n_pop, n_push);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
